serial_adder16: RTL and testbench

//  Bit-serial adder. Accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake.

---
 rtl/serial_adder16.sv | 125 ++++++++++++
 tb/tb_serial_adder16.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder16.sv
// Bit-serial adder: LSB-first add of two WIDTH-bit operands through one full adder and a carry flop.
// Optional SERIAL_ADDER_SUB_EN adds a sub input that turns the block into a subtractor (a - b).

module serial_adder16_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_adder16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADDER_SUB_EN
  ,
  input  logic             sub
`endif
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic             fa_sum, fa_carry;
  logic             accept, last_bit;

  assign accept   = in_valid && (state == IDLE);
  assign last_bit = (cnt == CW'(WIDTH - 1));

  serial_adder16_fa u_fa (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .ci (carry),
    .s  (fa_sum),
    .co (fa_carry)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_bit)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Handshake/status decode of the state register
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      RUN:     busy      = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready  = 1'b0;
    endcase
  end

  // Operand load on accept, one bit of sum per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      carry  <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
    end else if (accept) begin
      cnt  <= '0;
      a_sr <= a;
`ifdef SERIAL_ADDER_SUB_EN
      b_sr  <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
`else
      b_sr  <= b;
      carry <= cin;
`endif
    end else if (state == RUN) begin
      sum_sr <= WIDTH'({fa_sum, sum_sr} >> 1);
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      carry  <= fa_carry;
      cnt    <= cnt + CW'(1);
    end
  end

  assign sum  = sum_sr;
  assign cout = carry;

endmodule

// File: tb/tb_serial_adder16.sv
// Directed bench for serial_adder16 (WIDTH=16); define SERIAL_ADDER_SUB_EN to cover the subtract build.

module tb_serial_adder16;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif

  int checks   = 0;
  int failures = 0;

  serial_adder16 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef SERIAL_ADDER_SUB_EN
    ,
    .sub       (sub)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand set while idle, scramble inputs after accept, wait for out_valid.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic ocin,
                        output logic [W-1:0] s, output logic c, output int lat);
    a = oa; b = ob; cin = ocin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = ~oa; b = oa ^ ob ^ 16'h5A5A; cin = ~ocin;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    s = sum;
    c = cout;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (sum !== 16'h0000)   begin failures++; $display("FAIL reset_sum got=%h exp=0000", sum); end
    checks++; if (cout !== 1'b0)      begin failures++; $display("FAIL reset_cout got=%b exp=0", cout); end
  endtask

  task automatic test_add();
    logic [W-1:0] va[5] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h0000};
    logic [W-1:0] vb[5] = '{16'h4321, 16'h0000, 16'hFFFF, 16'h8000, 16'h0000};
    logic         vc[5] = '{1'b0,     1'b1,     1'b1,     1'b0,     1'b0};
    logic [W-1:0] es[5] = '{16'h5555, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
    logic         ec[5] = '{1'b0,     1'b1,     1'b1,     1'b1,     1'b0};
    logic [W-1:0] s;
    logic         c;
    int           lat;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], vc[i], s, c, lat);
      checks++; if (lat !== 16)    begin failures++; $display("FAIL add%0d_latency got=%0d exp=16", i, lat); end
      checks++; if (s !== es[i])   begin failures++; $display("FAIL add%0d_sum got=%h exp=%h", i, s, es[i]); end
      checks++; if (c !== ec[i])   begin failures++; $display("FAIL add%0d_cout got=%b exp=%b", i, c, ec[i]); end
      tick();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++; $display("FAIL add%0d_one_cycle_valid out_valid=%b in_ready=%b exp=0/1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] s;
    logic         c;
    int           lat;
    out_ready = 1'b0;
    run_op(16'h8001, 16'h8001, 1'b0, s, c, lat);
    checks++; if (lat !== 16 || s !== 16'h0002 || c !== 1'b1) begin
      failures++; $display("FAIL bp_first got lat=%0d sum=%h cout=%b exp 16/0002/1", lat, s, c);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 16'h1111 * 16'(i + 1); b = 16'hF0F0 ^ 16'(i); cin = i[0];
      tick();
      checks++; if (sum !== 16'h0002 || cout !== 1'b1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++; $display("FAIL bp_hold%0d sum=%h cout=%b out_valid=%b in_ready=%b exp 0002/1/1/0",
                             i, sum, cout, out_valid, in_ready);
      end
    end
    a = 16'h0001; b = 16'h0001; cin = 1'b1; out_ready = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL bp_release in_ready=%b out_valid=%b busy=%b exp 1/0/0", in_ready, out_valid, busy);
    end
    tick();
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_next_accept busy=%b exp=1", busy); end
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (out_valid) begin lat = n; break; end
    end
    checks++; if (lat !== 16 || sum !== 16'h0003 || cout !== 1'b0) begin
      failures++; $display("FAIL bp_next_result lat=%0d sum=%h cout=%b exp 16/0003/0", lat, sum, cout);
    end
    tick();
  endtask

  task automatic test_abort();
    logic [W-1:0] s;
    logic         c;
    int           lat;
    logic         seen;
    out_ready = 1'b1;
    a = 16'hAAAA; b = 16'h5555; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    checks++; if (sum === 16'h0000) begin failures++; $display("FAIL abort_partial sum=%h exp nonzero", sum); end
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0) begin
      failures++; $display("FAIL abort_reset in_ready=%b out_valid=%b busy=%b sum=%h cout=%b exp 1/0/0/0000/0",
                           in_ready, out_valid, busy, sum, cout);
    end
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_result saw out_valid=1 exp none"); end
    run_op(16'h1234, 16'h0001, 1'b0, s, c, lat);
    checks++; if (lat !== 16 || s !== 16'h1235 || c !== 1'b0) begin
      failures++; $display("FAIL abort_recover lat=%0d sum=%h cout=%b exp 16/1235/0", lat, s, c);
    end
    tick();
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    logic [W-1:0] s;
    logic         c;
    int           lat;
    out_ready = 1'b1;
    sub = 1'b1;
    run_op(16'h0005, 16'h0007, 1'b0, s, c, lat);
    checks++; if (lat !== 16 || s !== 16'hFFFE || c !== 1'b0) begin
      failures++; $display("FAIL sub_borrow lat=%0d sum=%h cout=%b exp 16/FFFE/0", lat, s, c);
    end
    tick();
    sub = 1'b1;
    run_op(16'h0007, 16'h0005, 1'b0, s, c, lat);
    checks++; if (lat !== 16 || s !== 16'h0002 || c !== 1'b1) begin
      failures++; $display("FAIL sub_noborrow lat=%0d sum=%h cout=%b exp 16/0002/1", lat, s, c);
    end
    tick();
    sub = 1'b0;
    run_op(16'h0007, 16'h0005, 1'b1, s, c, lat);
    checks++; if (s !== 16'h000D || c !== 1'b0) begin
      failures++; $display("FAIL sub_off sum=%h cout=%b exp 000D/0", s, c);
    end
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_abort();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
